// File: rtl/vscale_dmem_responder.sv
// Data-memory responder for the vscale data port: pipelined address/data phases,
// configurable wait states, byte-lane SRAM storage, and alignment/range error reporting.
module vscale_dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]       state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [IDX_W-1:0] idx_q;
  logic             wen_q, err_q;
  logic [3:0]       mask_q;

  logic [31:0]      mem [DEPTH_WORDS];

  logic [29:0]      word_off;
  logic [IDX_W-1:0] idx_c;
  logic [3:0]       mask_c;
  logic             err_c;
  logic             accept;
  logic             commit;
  logic [31:0]      wbits;
  logic [31:0]      rd_word;

  // Address-phase decode: word index, lane mask and error classification
  always_comb begin
    word_off = 30'((dmem_addr - BASE_ADDR) >> 2);
    idx_c    = word_off[IDX_W-1:0];
    mask_c   = 4'b0000;
    err_c    = 1'b0;
    case (dmem_size)
      3'd0: mask_c = 4'b0001 << dmem_addr[1:0];
      3'd1: begin
        mask_c = 4'b0011 << {dmem_addr[1], 1'b0};
        err_c  = dmem_addr[0];
      end
      3'd2: begin
        mask_c = 4'b1111;
        err_c  = (dmem_addr[1:0] != 2'b00);
      end
      default: err_c = 1'b1;
    endcase
    if ({2'b00, word_off} >= 32'(DEPTH_WORDS)) err_c = 1'b1;
  end

  assign accept = dmem_en && (state_q != S_WAIT);
  assign commit = (state_q == S_DATA) && wen_q && !err_q;

  always_comb begin
    wbits = '0;
    for (int b = 0; b < 4; b++) wbits[8*b +: 8] = {8{mask_q[b]}};
  end

  // Read word with forwarding from a write committing on the same edge
  always_comb begin
    rd_word = mem[idx_c];
    if (commit && (idx_q == idx_c)) rd_word = (rd_word & ~wbits) | (dmem_wdata_delayed & wbits);
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      S_WAIT: begin
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_n = S_DATA;
      end
      default: begin
        state_n = S_IDLE;
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_n = S_DATA;
          end else begin
            state_n = S_WAIT;
            cnt_n   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wen_q      <= 1'b0;
      err_q      <= 1'b0;
      mask_q     <= 4'b0000;
      dmem_rdata <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (accept) begin
        idx_q      <= idx_c;
        wen_q      <= dmem_wen;
        mask_q     <= mask_c;
        err_q      <= err_c;
        dmem_rdata <= err_c ? 32'h0 : rd_word;
      end
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) mem[idx_q][8*b +: 8] <= dmem_wdata_delayed[8*b +: 8];
      end
    end
  end

  assign dmem_wait     = (state_q == S_WAIT);
  assign dmem_badmem_e = (state_q == S_DATA) && err_q;

endmodule
